// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy encoding and
// the default field geometry used by every stage instance.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  localparam int PIPE_WIDTH      = 32;
  localparam int PIPE_NUM_FIELDS = 4;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; latency 1 cycle from inc to count.
// Holds at all-ones instead of wrapping; cleared only by reset.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid_buffer.sv
// Pipeline stage register with 2-entry skid storage; 1-cycle latency, strict FIFO.
// in_ready is registered (deasserts only when the skid entry is occupied); flush drops everything.
module pipe_stage_skid_buffer
  import pipe_pkg::*;
#(
  parameter int WIDTH      = PIPE_WIDTH,
  parameter int NUM_FIELDS = PIPE_NUM_FIELDS,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_FIELDS*WIDTH-1:0]   in_data,
  input  logic                          flush,
  input  logic                          stall,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_FIELDS*WIDTH-1:0]   out_data,
  output logic [1:0]                    occupancy,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int DW = NUM_FIELDS * WIDTH;

  pipe_state_e   state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_ready_q, in_ready_d;
  logic          acc, xfer;

  assign out_valid = (state_q != PS_EMPTY);
  assign acc       = in_valid & in_ready_q;
  assign xfer      = out_valid & out_ready & ~stall;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (acc) begin
            state_d = PS_ONE;
            main_d  = in_data;
          end
        end
        PS_ONE: begin
          if (acc && xfer) begin
            main_d = in_data;
          end else if (acc) begin
            state_d = PS_FULL;
            skid_d  = in_data;
          end else if (xfer) begin
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          // Skid entry promotes to main; skid_q keeps a stale copy that is never observed.
          if (xfer) begin
            state_d = PS_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  assign in_ready_d = (state_d != PS_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PS_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~xfer & ~flush),
    .count (stall_cnt)
  );

endmodule
